vec_exec_mb: RTL and testbench

Multi-beat, parametrised vector integer ALU; successor to the single-shot vec_exec. It accepts one RVV vector-vector instruction through a valid/ready handshake and executes VLEN bits in NUM_BEATS beats of NUM_PE*PE_W bits each. It adds vl tail handling with vd_old merge and early exit, plus illegal-op flagging. It sits between vector register-file read and writeback in the vector pipe.

---
 rtl/vec_pkg.sv | 68 ++++++
 rtl/vec_pe_alu.sv | 40 ++++
 rtl/vec_exec_mb.sv | 148 ++++++++++++++
 tb/tb_vec_exec_mb.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared types, funct6 encodings and per-element ALU helper for the multi-beat vector ALU.
// Elements are passed zero-extended to 64 bits; w selects the active element width.
package vec_pkg;

    typedef enum logic [1:0] {
        SEW_8  = 2'b00,
        SEW_16 = 2'b01,
        SEW_32 = 2'b10,
        SEW_64 = 2'b11
    } sew_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam logic [5:0] F6_VADD  = 6'b000000;
    localparam logic [5:0] F6_VSUB  = 6'b000010;
    localparam logic [5:0] F6_VMINU = 6'b000100;
    localparam logic [5:0] F6_VMIN  = 6'b000101;
    localparam logic [5:0] F6_VMAXU = 6'b000110;
    localparam logic [5:0] F6_VMAX  = 6'b000111;
    localparam logic [5:0] F6_VAND  = 6'b001001;
    localparam logic [5:0] F6_VOR   = 6'b001010;
    localparam logic [5:0] F6_VXOR  = 6'b001011;

    function automatic logic is_legal(input logic [5:0] f6, input logic [2:0] vsew);
        logic ok;
        ok = 1'b0;
        if (!vsew[2]) begin
            case (f6)
                F6_VADD, F6_VSUB, F6_VMINU, F6_VMIN, F6_VMAXU,
                F6_VMAX, F6_VAND, F6_VOR, F6_VXOR: ok = 1'b1;
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Signed compare flips the element sign bit so an unsigned compare orders two's complement.
    function automatic logic [63:0] elem_op(input logic [5:0] f6, input logic [63:0] a,
                                            input logic [63:0] b, input int unsigned w);
        logic [63:0] m;
        logic [63:0] sb;
        logic [63:0] r;
        logic        lt_u;
        logic        lt_s;
        m    = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        sb   = 64'd1 << (w - 1);
        lt_u = a < b;
        lt_s = (a ^ sb) < (b ^ sb);
        case (f6)
            F6_VADD:  r = (a + b) & m;
            F6_VSUB:  r = (a - b) & m;
            F6_VMINU: r = lt_u ? a : b;
            F6_VMIN:  r = lt_s ? a : b;
            F6_VMAXU: r = lt_u ? b : a;
            F6_VMAX:  r = lt_s ? b : a;
            F6_VAND:  r = a & b;
            F6_VOR:   r = a | b;
            F6_VXOR:  r = a ^ b;
            default:  r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vec_pe_alu.sv
// Combinational PE_W-bit SIMD ALU lane; all four element widths are evaluated and sew picks one.
module vec_pe_alu
    import vec_pkg::*;
#(
    parameter int PE_W = 64
) (
    input  sew_e              sew,
    input  logic [5:0]        funct6,
    input  logic [PE_W-1:0]   a,
    input  logic [PE_W-1:0]   b,
    output logic [PE_W-1:0]   y
);

    logic [PE_W-1:0] y8, y16, y32, y64;

    always_comb begin
        y8  = '0;
        y16 = '0;
        y32 = '0;
        y64 = '0;
        for (int e = 0; e < PE_W / 8; e++)
            y8[e*8 +: 8] = 8'(elem_op(funct6, 64'(a[e*8 +: 8]), 64'(b[e*8 +: 8]), 8));
        for (int e = 0; e < PE_W / 16; e++)
            y16[e*16 +: 16] = 16'(elem_op(funct6, 64'(a[e*16 +: 16]), 64'(b[e*16 +: 16]), 16));
        for (int e = 0; e < PE_W / 32; e++)
            y32[e*32 +: 32] = 32'(elem_op(funct6, 64'(a[e*32 +: 32]), 64'(b[e*32 +: 32]), 32));
        for (int e = 0; e < PE_W / 64; e++)
            y64[e*64 +: 64] = elem_op(funct6, a[e*64 +: 64], b[e*64 +: 64], 64);
    end

    always_comb begin
        case (sew)
            SEW_8:   y = y8;
            SEW_16:  y = y16;
            SEW_32:  y = y32;
            default: y = y64;
        endcase
    end

endmodule

// File: rtl/vec_exec_mb.sv
// Multi-beat vector integer ALU: one instruction at a time, CHUNK bits per beat, vl tail merge.
// Optional VEC_MASK_EN adds a per-element vmask input latched at accept.
// Handshake: a transfer happens on a rising edge where valid and ready are both high; the
// producer keeps payload stable while valid is high, and valid never depends on ready.
module vec_exec_mb
    import vec_pkg::*;
#(
    parameter  int VLEN   = 256,
    parameter  int NUM_PE = 2,
    parameter  int PE_W   = 64,
    localparam int VLW    = $clog2(VLEN / 8) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        vsew,
    input  logic [5:0]        funct6,
    input  logic [VLW-1:0]    vl,
    input  logic [VLEN-1:0]   operand_a,
    input  logic [VLEN-1:0]   operand_b,
    input  logic [VLEN-1:0]   vd_old,
`ifdef VEC_MASK_EN
    input  logic [VLEN/8-1:0] vmask,
`endif
    output logic [VLEN-1:0]   vec_exec_out,
    output logic              out_illegal,
    output logic              out_valid,
    input  logic              out_ready,
    output state_e            dbg_state
);

    localparam int CHUNK     = NUM_PE * PE_W;
    localparam int NUM_BEATS = VLEN / CHUNK;
    localparam int BW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    state_e          state_q, state_d;
    logic [BW-1:0]   beat_q;
    logic [1:0]      sew_q;
    logic [5:0]      f6_q;
    logic [VLW-1:0]  vl_q;
    logic [VLEN-1:0] a_q, b_q, res_q;
    logic            illegal_q, out_valid_q, in_ready_q;
`ifdef VEC_MASK_EN
    logic [VLEN/8-1:0] vmask_q;
`endif

    logic            accept, legal_in, last_beat;
    logic [31:0]     vlmax_in, covered, elem;
    logic [VLW-1:0]  vl_cl;
    logic [CHUNK-1:0] a_chunk, b_chunk, res_chunk, alu_y, merged;

    assign accept   = in_valid & in_ready_q;
    assign legal_in = is_legal(funct6, vsew);
    assign vlmax_in = 32'(VLEN) >> (32'd3 + 32'(vsew[1:0]));
    assign vl_cl    = (32'(vl) > vlmax_in) ? VLW'(vlmax_in) : vl;

    // Elements fully covered once this beat completes; reaching vl ends the instruction early.
    assign covered   = ((32'(beat_q) + 32'd1) * 32'(CHUNK)) >> (32'd3 + 32'(sew_q));
    assign last_beat = (int'(beat_q) == NUM_BEATS - 1) || (covered >= 32'(vl_q));

    assign a_chunk   = a_q[int'(beat_q)*CHUNK +: CHUNK];
    assign b_chunk   = b_q[int'(beat_q)*CHUNK +: CHUNK];
    assign res_chunk = res_q[int'(beat_q)*CHUNK +: CHUNK];

    for (genvar p = 0; p < NUM_PE; p++) begin : g_pe
        vec_pe_alu #(.PE_W(PE_W)) u_pe (
            .sew    (sew_e'(sew_q)),
            .funct6 (f6_q),
            .a      (a_chunk[p*PE_W +: PE_W]),
            .b      (b_chunk[p*PE_W +: PE_W]),
            .y      (alu_y[p*PE_W +: PE_W])
        );
    end

    // Byte-granular merge: a byte belongs to element (global byte index >> sew).
    always_comb begin
        merged = res_chunk;
        elem   = '0;
        for (int j = 0; j < CHUNK / 8; j++) begin
            elem = (32'(beat_q) * 32'(CHUNK / 8) + 32'(j)) >> sew_q;
`ifdef VEC_MASK_EN
            if (elem < 32'(vl_q) && vmask_q[elem[$clog2(VLEN/8)-1:0]])
                merged[j*8 +: 8] = alu_y[j*8 +: 8];
`else
            if (elem < 32'(vl_q))
                merged[j*8 +: 8] = alu_y[j*8 +: 8];
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (!legal_in || vl_cl == '0) ? DONE : EXEC;
            EXEC: if (last_beat) state_d = DONE;
            DONE: if (out_valid_q && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            sew_q       <= '0;
            f6_q        <= '0;
            vl_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
`ifdef VEC_MASK_EN
            vmask_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == IDLE);
            // out_valid follows entry into DONE by one edge and drops on the output transfer.
            out_valid_q <= (state_q == DONE) && !(out_valid_q && out_ready);
            if (accept) begin
                beat_q    <= '0;
                sew_q     <= vsew[1:0];
                f6_q      <= funct6;
                vl_q      <= vl_cl;
                a_q       <= operand_a;
                b_q       <= operand_b;
                res_q     <= vd_old;
                illegal_q <= !legal_in;
`ifdef VEC_MASK_EN
                vmask_q   <= vmask;
`endif
            end else if (state_q == EXEC) begin
                res_q[int'(beat_q)*CHUNK +: CHUNK] <= merged;
                beat_q <= beat_q + 1'b1;
            end
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_illegal  = illegal_q;
    assign vec_exec_out = res_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_vec_exec_mb.sv
// Directed and random stimulus for vec_exec_mb with an element-level reference model.
module tb_vec_exec_mb;
    import vec_pkg::*;

    localparam int VLEN  = 256;
    localparam int CHUNK = 128;
    localparam int VLW   = $clog2(VLEN / 8) + 1;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        vsew;
    logic [5:0]        funct6;
    logic [VLW-1:0]    vl;
    logic [VLEN-1:0]   operand_a, operand_b, vd_old;
    logic [VLEN/8-1:0] vmask;
    logic [VLEN-1:0]   vec_exec_out;
    logic              out_illegal;
    logic              out_valid;
    logic              out_ready;
    state_e            dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    logic [VLEN-1:0] exp_q[$];
    bit              ill_q[$];
    int              lat_q[$];
    logic [VLEN-1:0] last_out;

    vec_exec_mb #(.VLEN(VLEN), .NUM_PE(2), .PE_W(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .vsew         (vsew),
        .funct6       (funct6),
        .vl           (vl),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .vd_old       (vd_old),
`ifdef VEC_MASK_EN
        .vmask        (vmask),
`endif
        .vec_exec_out (vec_exec_out),
        .out_illegal  (out_illegal),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit bench_illegal(input logic [2:0] s, input logic [5:0] f);
        return s[2] || !(f inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h06, 6'h07, 6'h09, 6'h0A, 6'h0B});
    endfunction

    // Reference: walk elements, sign-extend for signed ops, splice results into vd_old.
    function automatic logic [VLEN-1:0] model(input logic [2:0] s, input logic [5:0] f, input int v,
                                              input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                                              input logic [VLEN-1:0] d, input logic [VLEN/8-1:0] m);
        int sew, n;
        logic [63:0] mask, ea, eb, r;
        longint sa, sb;
        logic [VLEN-1:0] res;
        res = d;
        if (bench_illegal(s, f)) return d;
        sew  = 8 << s[1:0];
        n    = (v > VLEN / sew) ? VLEN / sew : v;
        mask = (sew == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << sew) - 64'd1);
        for (int e = 0; e < n; e++) begin
`ifdef VEC_MASK_EN
            if (!m[e]) continue;
`endif
            ea = 64'(a >> (e * sew)) & mask;
            eb = 64'(b >> (e * sew)) & mask;
            sa = $signed(ea << (64 - sew)) >>> (64 - sew);
            sb = $signed(eb << (64 - sew)) >>> (64 - sew);
            case (f)
                6'h00:   r = (ea + eb) & mask;
                6'h02:   r = (ea - eb) & mask;
                6'h04:   r = (ea < eb) ? ea : eb;
                6'h05:   r = (sa < sb) ? ea : eb;
                6'h06:   r = (ea > eb) ? ea : eb;
                6'h07:   r = (sa > sb) ? ea : eb;
                6'h09:   r = ea & eb;
                6'h0A:   r = ea | eb;
                default: r = ea ^ eb;
            endcase
            res = (res & ~(VLEN'(mask) << (e * sew))) | (VLEN'(r) << (e * sew));
        end
        return res;
    endfunction

    task automatic issue(input logic [2:0] s, input logic [5:0] f, input int v,
                         input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                         input logic [VLEN-1:0] d, input logic [VLEN/8-1:0] m);
        int t, sew, n, k;
        bit ill;
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready_before_issue", VLEN'(in_ready), VLEN'(1));
        vsew = s; funct6 = f; vl = VLW'(v);
        operand_a = a; operand_b = b; vd_old = d; vmask = m;
        in_valid = 1'b1;
        ill = bench_illegal(s, f);
        sew = 8 << s[1:0];
        n   = (v > VLEN / sew) ? VLEN / sew : v;
        k   = (n * sew + CHUNK - 1) / CHUNK;
        exp_q.push_back(model(s, f, v, a, b, d, m));
        ill_q.push_back(ill);
        lat_q.push_back((ill || n == 0) ? 1 : k + 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int lat;
        logic [VLEN-1:0] e;
        bit ei;
        int el;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        e = exp_q.pop_front();
        ei = ill_q.pop_front();
        el = lat_q.pop_front();
        chk({tag, "_latency"}, VLEN'(lat), VLEN'(el));
        chk({tag, "_data"}, vec_exec_out, e);
        chk({tag, "_illegal"}, VLEN'(out_illegal), VLEN'(ei));
        last_out = vec_exec_out;
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, VLEN'(out_valid), VLEN'(0));
        chk({tag, "_ready_back"}, VLEN'(in_ready), VLEN'(1));
    endtask

    task automatic run_op(input string tag, input logic [2:0] s, input logic [5:0] f, input int v,
                          input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                          input logic [VLEN-1:0] d, input logic [VLEN/8-1:0] m);
        issue(s, f, v, a, b, d, m);
        wait_out(tag);
        handshake(tag);
    endtask

    function automatic logic [VLEN-1:0] rnd_vec();
        logic [VLEN-1:0] r;
        for (int i = 0; i < VLEN / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    logic [VLEN-1:0] a_v, b_v, d_v, hold;
    logic [VLEN/8-1:0] all_m;
    logic [5:0] ops [9];

    initial begin
        ops = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h06, 6'h07, 6'h09, 6'h0A, 6'h0B};
        all_m = '1;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        vsew = '0; funct6 = '0; vl = '0;
        operand_a = '0; operand_b = '0; vd_old = '0; vmask = '1;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_out", vec_exec_out, '0);
        chk("rst_valid", VLEN'(out_valid), VLEN'(0));
        chk("rst_ready", VLEN'(in_ready), VLEN'(0));
        chk("rst_illegal", VLEN'(out_illegal), VLEN'(0));
        chk("rst_state", VLEN'(dbg_state), VLEN'(IDLE));
        reset = 1'b1;
        #1 chk("ready_before_edge", VLEN'(in_ready), VLEN'(0));
        @(negedge clk);
        chk("ready_after_edge", VLEN'(in_ready), VLEN'(1));

        // vadd SEW=32 wraps to zero over two beats
        run_op("vadd_wrap", 3'b010, 6'h00, 8, {8{32'hFFFF_FFFF}}, {8{32'h1}}, rnd_vec(), all_m);
        chk("vadd_wrap_zero", last_out, '0);

        // vl=3 tail keeps vd_old, early exit after one beat
        run_op("vadd_tail", 3'b010, 6'h00, 3, {8{32'h1}}, {8{32'h1}}, {32{8'hA5}}, all_m);
        chk("vadd_tail_lit", last_out, {{5{32'hA5A5_A5A5}}, {3{32'h2}}});

        // SEW=8 signed/unsigned boundary at byte 0
        a_v = rnd_vec(); a_v[7:0] = 8'h80;
        b_v = rnd_vec(); b_v[7:0] = 8'h7F;
        run_op("vmax8", 3'b000, 6'h07, 32, a_v, b_v, rnd_vec(), all_m);
        chk("vmax8_b0", VLEN'(last_out[7:0]), VLEN'(8'h7F));
        run_op("vmaxu8", 3'b000, 6'h06, 32, a_v, b_v, rnd_vec(), all_m);
        chk("vmaxu8_b0", VLEN'(last_out[7:0]), VLEN'(8'h80));
        run_op("vmin8", 3'b000, 6'h05, 32, a_v, b_v, rnd_vec(), all_m);
        chk("vmin8_b0", VLEN'(last_out[7:0]), VLEN'(8'h80));
        run_op("vsub8", 3'b000, 6'h02, 32, a_v, b_v, rnd_vec(), all_m);
        chk("vsub8_b0", VLEN'(last_out[7:0]), VLEN'(8'h01));

        // vl above VLMAX clamps; vl=0 returns vd_old
        run_op("clamp64", 3'b011, 6'h0B, 20, rnd_vec(), rnd_vec(), rnd_vec(), all_m);
        d_v = rnd_vec();
        run_op("vl_zero", 3'b001, 6'h00, 0, rnd_vec(), rnd_vec(), d_v, all_m);
        chk("vl_zero_lit", last_out, d_v);

        // Back-pressure: output held, new request waits
        issue(3'b001, 6'h04, 16, rnd_vec(), rnd_vec(), rnd_vec(), all_m);
        wait_out("bp1");
        hold = last_out;
        a_v = rnd_vec(); b_v = rnd_vec(); d_v = rnd_vec();
        vsew = 3'b010; funct6 = 6'h0A; vl = VLW'(5);
        operand_a = a_v; operand_b = b_v; vd_old = d_v; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_valid", VLEN'(out_valid), VLEN'(1));
            chk("bp_data", vec_exec_out, hold);
            chk("bp_ready", VLEN'(in_ready), VLEN'(0));
        end
        handshake("bp1");
        issue(3'b010, 6'h0A, 5, a_v, b_v, d_v, all_m);
        wait_out("bp2");
        handshake("bp2");

        // Illegal vsew and illegal funct6
        run_op("ill_sew", 3'b101, 6'h00, 8, rnd_vec(), rnd_vec(), {32{8'h3C}}, all_m);
        chk("ill_sew_lit", last_out, {32{8'h3C}});
        run_op("ill_f6", 3'b000, 6'h3F, 8, rnd_vec(), rnd_vec(), {32{8'h3C}}, all_m);

        // Reset during EXEC beat 0
        issue(3'b000, 6'h00, 32, rnd_vec(), rnd_vec(), rnd_vec(), all_m);
        reset = 1'b0;
        #1;
        chk("mid_rst_out", vec_exec_out, '0);
        chk("mid_rst_valid", VLEN'(out_valid), VLEN'(0));
        chk("mid_rst_ready", VLEN'(in_ready), VLEN'(0));
        chk("mid_rst_illegal", VLEN'(out_illegal), VLEN'(0));
        void'(exp_q.pop_back()); void'(ill_q.pop_back()); void'(lat_q.pop_back());
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        #1 chk("mid_rel_ready0", VLEN'(in_ready), VLEN'(0));
        @(negedge clk);
        chk("mid_rel_ready1", VLEN'(in_ready), VLEN'(1));
        run_op("after_rst", 3'b001, 6'h09, 11, rnd_vec(), rnd_vec(), rnd_vec(), all_m);

        // Random legal operations
        for (int i = 0; i < 24; i++) begin
            run_op("rand", 3'($urandom_range(0, 3)), ops[$urandom_range(0, 8)],
                   int'($urandom_range(0, 40)), rnd_vec(), rnd_vec(), rnd_vec(), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
